fish_motion_ctrl: RTL and testbench
===================================

FISH_MOTION_CTRL -- requirements
Module: fish_motion_ctrl

Interface
REQ-001 SHALL have parameter SPEED, default 2, horizontal pixels moved per frame_tick while swimming.
REQ-002 SHALL have parameter REEL_SPEED, default 3, vertical pixels moved up per frame_tick while reeled.
REQ-003 SHALL have parameter REEL_TOP, default 40, v_position at or below which a reeled fish counts as landed.
REQ-004 SHALL have parameter START_H, default 680, spawn h_position for a left-swimming fish.
REQ-005 SHALL have parameter SEED, default 10'h2A5, LFSR reset value (nonzero).
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame; all motion occurs only on it.
REQ-009 spawn_en  input  1  game running; 0 forces the fish away.
REQ-010 hook_active  input  1  hook is in the water.
REQ-011 hook_h, hook_v  input  10 each  hook tip pixel coordinates.
REQ-012 fish_h_position, fish_v_position  output  10 each  sprite anchor for the fish renderer.
REQ-013 fish_way  output  2  0 swim left, 1 swim right, 2 reeled up.
REQ-014 fish_appear  output  1  fish visible.
REQ-015 caught  output  1  one-cycle pulse when a reeled fish lands.

Function
REQ-016 SHALL implement states IDLE, DELAY, SWIM, REEL; all outputs registered.
REQ-017 SHALL keep a 10-bit Fibonacci LFSR (x^10+x^7+1) that advances only on frame_tick.
REQ-018 IDLE: fish_appear=0; when spawn_en=1, next cycle enters DELAY.
REQ-019 On every entry to DELAY SHALL latch from the current LFSR: frame count = lfsr[5:0]+8, direction = lfsr[0], row = 120 + lfsr[9:2].
REQ-020 DELAY: fish_appear=0; counter decrements per frame_tick; the tick on which it reaches 0 enters SWIM.
REQ-021 SWIM entry: fish_way=latched direction, fish_v_position=row, fish_h_position=START_H if left, 0 if right; fish_appear=1.
REQ-022 SWIM per frame_tick: h -= SPEED (left) or h += SPEED (right); 10-bit arithmetic, no wrap permitted.
REQ-023 SWIM exit: left when h <= SPEED before the update, right when h >= START_H before the update -> DELAY, fish_appear=0.
REQ-024 Catch test on each SWIM frame_tick: hook_active=1 and hook_h in [h-40, h-1] and hook_v in [v, v+34], evaluated on pre-update position.
REQ-025 Catch -> REEL: fish_way=2, fish_h_position=hook_h+17, fish_v_position=hook_v, fish_appear=1.
REQ-026 REEL per frame_tick: v -= REEL_SPEED; when v <= REEL_TOP before the update: caught=1 for that cycle, enter DELAY.
REQ-027 Catch and edge exit on the same tick: catch wins.
REQ-028 spawn_en=0 in DELAY or SWIM: next cycle IDLE, fish_appear=0; REEL always completes, then IDLE instead of DELAY.
REQ-029 fish_h_position, fish_v_position, fish_way hold their last values whenever fish_appear=0.

Reset
REQ-030 On rst_n=0 at a clk edge: state IDLE, LFSR=SEED, counters 0, h=0, v=0, way=0, appear=0, caught=0.
REQ-031 Reset SHALL override every other input, including mid-SWIM and mid-REEL.

Structure
REQ-032 State encoding, fish box sizes (40x35), row base 120, and delay offset 8 SHALL live in shared package fish_pkg.
REQ-033 The LFSR SHALL be a sub-module lfsr10 (clk, rst_n, en, seed, q).

Verification
REQ-034 Reset, hold 5 cycles -> appear=0, caught=0, h=v=0, way=0; LFSR=0x2A5.
REQ-035 spawn_en=1 from reset, no prior ticks -> exactly 45 frame_ticks in DELAY, then way=1, v=289, h=0, appear=1.
REQ-036 Right swim, no hook -> h=2,4,... per tick; tick at h=680 -> appear=0, DELAY.
REQ-037 Right swim at h=100, v=289, hook_active=1, hook (80,300) -> next cycle way=2, h=97, v=300; after 87 ticks v=39, next tick caught pulses once.
REQ-038 spawn_en dropped mid-SWIM -> next cycle IDLE, appear=0; dropped mid-REEL -> reel finishes, caught pulses, then IDLE.
REQ-039 rst_n=0 during REEL -> next cycle all outputs at reset values, caught never asserted.

Source files
------------

// File: rtl/fish_pkg.sv
// Shared definitions for the fish motion controller: state encoding,
// heading codes, fish hit-box geometry and spawn timing constants.
package fish_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SWIM  = 2'd2,
        ST_REEL  = 2'd3
    } fish_state_t;

    localparam logic [1:0] WAY_LEFT  = 2'd0;
    localparam logic [1:0] WAY_RIGHT = 2'd1;
    localparam logic [1:0] WAY_REEL  = 2'd2;

    localparam int FISH_W       = 40;
    localparam int FISH_H       = 35;
    localparam int ROW_BASE     = 120;
    localparam int DELAY_OFFSET = 8;
    localparam int HOOK_OFFSET  = 17;

    // Hook tip inside the fish box: columns [h-40, h-1], rows [v, v+34].
    // Done in 11 bits so a fish near the left edge cannot underflow the box.
    function automatic logic hook_in_box(
        input logic [9:0] fish_h,
        input logic [9:0] fish_v,
        input logic [9:0] tip_h,
        input logic [9:0] tip_v
    );
        logic [10:0] fh, fv, th, tv;
        fh = {1'b0, fish_h};
        fv = {1'b0, fish_v};
        th = {1'b0, tip_h};
        tv = {1'b0, tip_v};
        return (th + 11'(FISH_W) >= fh) && (th < fh) &&
               (tv >= fv) && (tv <= fv + 11'(FISH_H - 1));
    endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1, stepping only when en=1.
module lfsr10 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [9:0] seed,
    output logic [9:0] q
);

    logic feedback;

    assign feedback = q[9] ^ q[6];

    // Shift register with synchronous reload of the seed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= seed;
        end else if (en) begin
            q <= {q[8:0], feedback};
        end
    end

endmodule

// File: rtl/fish_motion_ctrl.sv
// Fish motion controller: spawns a fish after a random frame delay, swims it
// across the screen, and reels it up to the surface when the hook touches it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | game stopped, no fish; waits for spawn_en
// ST_DELAY | fish hidden, counting frames before the next spawn
// ST_SWIM  | fish visible, moving horizontally, hook tested each frame
// ST_REEL  | fish hooked, rising by REEL_SPEED per frame until landed
module fish_motion_ctrl
    import fish_pkg::*;
#(
    parameter int         SPEED      = 2,
    parameter int         REEL_SPEED = 3,
    parameter int         REEL_TOP   = 40,
    parameter int         START_H    = 680,
    parameter logic [9:0] SEED       = 10'h2A5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       spawn_en,
    input  logic       hook_active,
    input  logic [9:0] hook_h,
    input  logic [9:0] hook_v,
    output logic [9:0] fish_h_position,
    output logic [9:0] fish_v_position,
    output logic [1:0] fish_way,
    output logic       fish_appear,
    output logic       caught
);

    fish_state_t state, state_nxt;
    logic [6:0]  delay_cnt, delay_cnt_nxt;
    logic        dir_lat, dir_lat_nxt;
    logic [9:0]  row_lat, row_lat_nxt;
    logic        reel_abort, reel_abort_nxt;
    logic [9:0]  h_nxt, v_nxt;
    logic [1:0]  way_nxt;
    logic        appear_nxt, caught_nxt;
    logic [9:0]  lfsr_q;
    logic        hit, at_edge;

    lfsr10 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (frame_tick),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign hit     = hook_active &&
                     hook_in_box(fish_h_position, fish_v_position, hook_h, hook_v);
    assign at_edge = (fish_way == WAY_LEFT) ? (fish_h_position <= 10'(SPEED))
                                            : (fish_h_position >= 10'(START_H));

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            delay_cnt       <= '0;
            dir_lat         <= 1'b0;
            row_lat         <= '0;
            reel_abort      <= 1'b0;
            fish_h_position <= '0;
            fish_v_position <= '0;
            fish_way        <= WAY_LEFT;
            fish_appear     <= 1'b0;
            caught          <= 1'b0;
        end else begin
            state           <= state_nxt;
            delay_cnt       <= delay_cnt_nxt;
            dir_lat         <= dir_lat_nxt;
            row_lat         <= row_lat_nxt;
            reel_abort      <= reel_abort_nxt;
            fish_h_position <= h_nxt;
            fish_v_position <= v_nxt;
            fish_way        <= way_nxt;
            fish_appear     <= appear_nxt;
            caught          <= caught_nxt;
        end
    end

    // Next-state and next-output logic. Every entry into ST_DELAY snapshots
    // the LFSR for the delay length, heading and row of the next fish.
    always_comb begin
        state_nxt      = state;
        delay_cnt_nxt  = delay_cnt;
        dir_lat_nxt    = dir_lat;
        row_lat_nxt    = row_lat;
        reel_abort_nxt = reel_abort;
        h_nxt          = fish_h_position;
        v_nxt          = fish_v_position;
        way_nxt        = fish_way;
        appear_nxt     = fish_appear;
        caught_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                appear_nxt = 1'b0;
                if (spawn_en) begin
                    state_nxt     = ST_DELAY;
                    delay_cnt_nxt = 7'(DELAY_OFFSET) + {1'b0, lfsr_q[5:0]};
                    dir_lat_nxt   = lfsr_q[0];
                    row_lat_nxt   = 10'(ROW_BASE) + {2'b00, lfsr_q[9:2]};
                end
            end
            ST_DELAY: begin
                appear_nxt = 1'b0;
                if (!spawn_en) begin
                    state_nxt = ST_IDLE;
                end else if (frame_tick) begin
                    if (delay_cnt <= 7'd1) begin
                        state_nxt     = ST_SWIM;
                        delay_cnt_nxt = '0;
                        way_nxt       = dir_lat ? WAY_RIGHT : WAY_LEFT;
                        v_nxt         = row_lat;
                        h_nxt         = dir_lat ? 10'd0 : 10'(START_H);
                        appear_nxt    = 1'b1;
                    end else begin
                        delay_cnt_nxt = delay_cnt - 7'd1;
                    end
                end
            end
            ST_SWIM: begin
                if (!spawn_en) begin
                    state_nxt  = ST_IDLE;
                    appear_nxt = 1'b0;
                end else if (frame_tick) begin
                    // A catch on the edge frame takes priority over leaving.
                    if (hit) begin
                        state_nxt      = ST_REEL;
                        way_nxt        = WAY_REEL;
                        h_nxt          = 10'(hook_h + 10'(HOOK_OFFSET));
                        v_nxt          = hook_v;
                        appear_nxt     = 1'b1;
                        reel_abort_nxt = 1'b0;
                    end else if (at_edge) begin
                        state_nxt     = ST_DELAY;
                        appear_nxt    = 1'b0;
                        delay_cnt_nxt = 7'(DELAY_OFFSET) + {1'b0, lfsr_q[5:0]};
                        dir_lat_nxt   = lfsr_q[0];
                        row_lat_nxt   = 10'(ROW_BASE) + {2'b00, lfsr_q[9:2]};
                    end else if (fish_way == WAY_LEFT) begin
                        h_nxt = fish_h_position - 10'(SPEED);
                    end else begin
                        h_nxt = fish_h_position + 10'(SPEED);
                    end
                end
            end
            ST_REEL: begin
                // A hooked fish always lands; a stop request only changes
                // where we go afterwards.
                if (!spawn_en) begin
                    reel_abort_nxt = 1'b1;
                end
                if (frame_tick) begin
                    if (fish_v_position <= 10'(REEL_TOP)) begin
                        caught_nxt = 1'b1;
                        appear_nxt = 1'b0;
                        if (reel_abort_nxt) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt     = ST_DELAY;
                            delay_cnt_nxt = 7'(DELAY_OFFSET) + {1'b0, lfsr_q[5:0]};
                            dir_lat_nxt   = lfsr_q[0];
                            row_lat_nxt   = 10'(ROW_BASE) + {2'b00, lfsr_q[9:2]};
                        end
                    end else begin
                        v_nxt = fish_v_position - 10'(REEL_SPEED);
                    end
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                appear_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fish_motion_ctrl.sv
// Directed testbench for fish_motion_ctrl with default parameters.
module tb_fish_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       spawn_en = 1'b0;
    logic       hook_active = 1'b0;
    logic [9:0] hook_h = '0;
    logic [9:0] hook_v = '0;
    logic [9:0] fish_h_position, fish_v_position;
    logic [1:0] fish_way;
    logic       fish_appear, caught;

    int checks = 0;
    int fails = 0;
    int caught_cnt = 0;

    fish_motion_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .spawn_en        (spawn_en),
        .hook_active     (hook_active),
        .hook_h          (hook_h),
        .hook_v          (hook_v),
        .fish_h_position (fish_h_position),
        .fish_v_position (fish_v_position),
        .fish_way        (fish_way),
        .fish_appear     (fish_appear),
        .caught          (caught)
    );

    always #5 clk = ~clk;

    // Count caught pulses, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (caught === 1'b1) caught_cnt++;
    end

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; spawn_en = 1'b0; hook_active = 1'b0; frame_tick = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset, spawn the first fish (right, row 289), swim to h=100, hook it.
    task automatic go_to_catch();
        apply_reset();
        spawn_en = 1'b1;
        @(negedge clk);
        repeat (95) tick();
        hook_h = 10'd80; hook_v = 10'd300; hook_active = 1'b1;
        tick();
        hook_active = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; spawn_en = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (fish_appear !== 1'b0) begin fails++; $display("FAIL reset_appear got %b exp 0", fish_appear); end
        checks++; if (caught !== 1'b0) begin fails++; $display("FAIL reset_caught got %b exp 0", caught); end
        checks++; if (fish_h_position !== 10'd0) begin fails++; $display("FAIL reset_h got %0d exp 0", fish_h_position); end
        checks++; if (fish_v_position !== 10'd0) begin fails++; $display("FAIL reset_v got %0d exp 0", fish_v_position); end
        checks++; if (fish_way !== 2'd0) begin fails++; $display("FAIL reset_way got %0d exp 0", fish_way); end
        checks++; if (dut.u_lfsr.q !== 10'h2A5) begin fails++; $display("FAIL reset_lfsr got %h exp 2a5", dut.u_lfsr.q); end
    endtask

    task automatic test_spawn_delay();
        rst_n = 1'b1; spawn_en = 1'b1;
        @(negedge clk);
        repeat (44) tick();
        checks++; if (fish_appear !== 1'b0) begin fails++; $display("FAIL delay_44_appear got %b exp 0", fish_appear); end
        tick();
        checks++; if (fish_appear !== 1'b1) begin fails++; $display("FAIL delay_45_appear got %b exp 1", fish_appear); end
        checks++; if (fish_way !== 2'd1) begin fails++; $display("FAIL spawn_way got %0d exp 1", fish_way); end
        checks++; if (fish_v_position !== 10'd289) begin fails++; $display("FAIL spawn_v got %0d exp 289", fish_v_position); end
        checks++; if (fish_h_position !== 10'd0) begin fails++; $display("FAIL spawn_h got %0d exp 0", fish_h_position); end
    endtask

    task automatic test_swim_right();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (fish_h_position !== 10'(2 * i)) begin fails++; $display("FAIL swim_step got %0d exp %0d", fish_h_position, 2 * i); end
        end
        repeat (337) tick();
        checks++; if (fish_h_position !== 10'd680 || fish_appear !== 1'b1) begin fails++; $display("FAIL swim_at_edge got h=%0d appear=%b exp h=680 appear=1", fish_h_position, fish_appear); end
        tick();
        checks++; if (fish_appear !== 1'b0) begin fails++; $display("FAIL edge_exit_appear got %b exp 0", fish_appear); end
        repeat (3) tick();
        checks++; if (fish_h_position !== 10'd680 || fish_v_position !== 10'd289 || fish_way !== 2'd1 || fish_appear !== 1'b0) begin
            fails++; $display("FAIL hidden_hold got h=%0d v=%0d way=%0d appear=%b exp 680 289 1 0", fish_h_position, fish_v_position, fish_way, fish_appear);
        end
    endtask

    task automatic test_respawn();
        int n;
        n = 0;
        while (fish_appear !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        checks++; if (fish_appear !== 1'b1) begin fails++; $display("FAIL respawn_timeout got appear=%b exp 1 within 80 ticks", fish_appear); end
        else begin
            checks++;
            if (!((fish_way == 2'd0 && fish_h_position == 10'd680) || (fish_way == 2'd1 && fish_h_position == 10'd0))
                || fish_v_position < 10'd120 || fish_v_position > 10'd375) begin
                fails++; $display("FAIL respawn_pos got way=%0d h=%0d v=%0d exp way0@680 or way1@0, v in 120..375", fish_way, fish_h_position, fish_v_position);
            end
        end
    endtask

    task automatic test_catch();
        int c0;
        apply_reset();
        spawn_en = 1'b1;
        @(negedge clk);
        repeat (94) tick();
        checks++; if (fish_h_position !== 10'd98) begin fails++; $display("FAIL pre_catch_h got %0d exp 98", fish_h_position); end
        hook_h = 10'd98; hook_v = 10'd300; hook_active = 1'b1;
        tick();
        checks++; if (fish_way !== 2'd1 || fish_h_position !== 10'd100) begin fails++; $display("FAIL hook_miss got way=%0d h=%0d exp 1 100", fish_way, fish_h_position); end
        hook_h = 10'd80;
        tick();
        hook_active = 1'b0;
        checks++; if (fish_way !== 2'd2 || fish_h_position !== 10'd97 || fish_v_position !== 10'd300 || fish_appear !== 1'b1) begin
            fails++; $display("FAIL catch got way=%0d h=%0d v=%0d appear=%b exp 2 97 300 1", fish_way, fish_h_position, fish_v_position, fish_appear);
        end
        c0 = caught_cnt;
        repeat (87) tick();
        checks++; if (fish_v_position !== 10'd39 || caught_cnt != c0) begin fails++; $display("FAIL reel_top got v=%0d pulses=%0d exp 39 0", fish_v_position, caught_cnt - c0); end
        tick();
        checks++; if (caught !== 1'b1 || fish_appear !== 1'b0) begin fails++; $display("FAIL land got caught=%b appear=%b exp 1 0", caught, fish_appear); end
        @(negedge clk);
        checks++; if (caught !== 1'b0 || caught_cnt != c0 + 1) begin fails++; $display("FAIL land_pulse got caught=%b pulses=%0d exp 0 1", caught, caught_cnt - c0); end
    endtask

    task automatic test_drop_swim();
        apply_reset();
        spawn_en = 1'b1;
        @(negedge clk);
        repeat (55) tick();
        spawn_en = 1'b0;
        @(negedge clk);
        checks++; if (fish_appear !== 1'b0 || fish_h_position !== 10'd20) begin fails++; $display("FAIL drop_swim got appear=%b h=%0d exp 0 20", fish_appear, fish_h_position); end
        repeat (80) tick();
        checks++; if (fish_appear !== 1'b0) begin fails++; $display("FAIL drop_swim_idle got appear=%b exp 0", fish_appear); end
    endtask

    task automatic test_drop_reel();
        int c0;
        go_to_catch();
        repeat (5) tick();
        spawn_en = 1'b0;
        c0 = caught_cnt;
        repeat (5) tick();
        checks++; if (fish_appear !== 1'b1 || fish_v_position !== 10'd270) begin fails++; $display("FAIL drop_reel_cont got appear=%b v=%0d exp 1 270", fish_appear, fish_v_position); end
        repeat (78) tick();
        checks++; if (caught_cnt != c0 + 1 || fish_appear !== 1'b0) begin fails++; $display("FAIL drop_reel_land got pulses=%0d appear=%b exp 1 0", caught_cnt - c0, fish_appear); end
        repeat (80) tick();
        checks++; if (fish_appear !== 1'b0 || caught_cnt != c0 + 1) begin fails++; $display("FAIL drop_reel_idle got appear=%b pulses=%0d exp 0 1", fish_appear, caught_cnt - c0); end
    endtask

    task automatic test_reset_reel();
        int c0;
        go_to_catch();
        repeat (10) tick();
        c0 = caught_cnt;
        @(negedge clk);
        rst_n = 1'b0; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++; if (fish_appear !== 1'b0 || fish_way !== 2'd0 || fish_h_position !== 10'd0 || fish_v_position !== 10'd0 || caught !== 1'b0) begin
            fails++; $display("FAIL reset_in_reel got appear=%b way=%0d h=%0d v=%0d caught=%b exp all 0", fish_appear, fish_way, fish_h_position, fish_v_position, caught);
        end
        repeat (100) tick();
        checks++; if (caught_cnt != c0 || fish_appear !== 1'b0) begin fails++; $display("FAIL reset_hold got pulses=%0d appear=%b exp 0 0", caught_cnt - c0, fish_appear); end
        rst_n = 1'b1;
        spawn_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spawn_delay();
        test_swim_right();
        test_respawn();
        test_catch();
        test_drop_swim();
        test_drop_reel();
        test_reset_reel();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
